serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 158 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around an external 1-bit full adder
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             fa_A,
  output logic             fa_B,
  output logic             fa_Ci,
  input  logic             fa_Co,
  input  logic             fa_So,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Co,
  output logic             Ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  // Holds the WIDTH-1 low result bits gathered so far; the MSB comes straight
  // from the adder on the final edge, so no extra flop is needed for it.
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sum_cat;

  assign accept   = (state_q == S_IDLE) && start;
  assign last_bit = (state_q == S_RUN) && (idx_q == LAST_IDX);
  assign sum_cat  = {fa_So, sum_sh_q};

  // State register; reset returns the sequencer to IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE waits for start, RUN lasts exactly WIDTH cycles, DONE lasts one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: adder is driven only during RUN so it sees idle zeros otherwise.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    fa_A  = 1'b0;
    fa_B  = 1'b0;
    fa_Ci = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_RUN: begin
        busy  = 1'b1;
        fa_A  = a_q[0];
        fa_B  = b_q[0];
        fa_Ci = carry_q;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Datapath next values: latch operands on accept, shift one bit per RUN cycle,
  // and commit the full result only on the last bit so Sum never shows partials.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_d     = A;
      b_d     = Sub ? ~B : B;
      carry_d = Sub ? 1'b1 : Cin;
      idx_d   = '0;
    end else if (state_q == S_RUN) begin
      a_d      = a_q >> 1;
      b_d      = b_q >> 1;
      sum_sh_d = sum_cat[WIDTH-1:1];
      carry_d  = fa_Co;
      idx_d    = idx_q + 1'b1;
      if (last_bit) begin
        sum_d = sum_cat;
        co_d  = fa_Co;
        // Carry into the MSB differs from carry out of it exactly on signed overflow.
        ovf_d = fa_Co ^ fa_Ci;
      end
    end
  end

  // Datapath registers; reset discards any partial operation and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Sum = sum_q;
  assign Co  = co_q;
  assign Ovf = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl (WIDTH=8 directed, WIDTH=4 sweep)
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=8 instance
  logic       start, sub, cin;
  logic [7:0] a, b;
  logic       fa_a, fa_b, fa_ci, fa_co, fa_so;
  logic       busy, done;
  logic [7:0] sum;
  logic       co, ovf;

  // WIDTH=4 instance
  logic       s4_start, s4_sub, s4_cin;
  logic [3:0] s4_a, s4_b;
  logic       s4_fa_a, s4_fa_b, s4_fa_ci, s4_fa_co, s4_fa_so;
  logic       s4_busy, s4_done;
  logic [3:0] s4_sum;
  logic       s4_co, s4_ovf;

  // Full-adder cells modelled by the bench
  assign fa_so    = fa_a ^ fa_b ^ fa_ci;
  assign fa_co    = (fa_a & fa_b) | (fa_ci & (fa_a ^ fa_b));
  assign s4_fa_so = s4_fa_a ^ s4_fa_b ^ s4_fa_ci;
  assign s4_fa_co = (s4_fa_a & s4_fa_b) | (s4_fa_ci & (s4_fa_a ^ s4_fa_b));

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .Sub(sub), .A(a), .B(b), .Cin(cin),
    .fa_A(fa_a), .fa_B(fa_b), .fa_Ci(fa_ci), .fa_Co(fa_co), .fa_So(fa_so),
    .busy(busy), .done(done), .Sum(sum), .Co(co), .Ovf(ovf)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4_start), .Sub(s4_sub), .A(s4_a), .B(s4_b), .Cin(s4_cin),
    .fa_A(s4_fa_a), .fa_B(s4_fa_b), .fa_Ci(s4_fa_ci), .fa_Co(s4_fa_co), .fa_So(s4_fa_so),
    .busy(s4_busy), .done(s4_done), .Sum(s4_sum), .Co(s4_co), .Ovf(s4_ovf)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt8 = 0;

  logic [9:0] exp8_q[$];
  logic [5:0] exp4_q[$];
  logic [9:0] e8;
  logic [5:0] e4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference for the sweep: {Sum, Co, Ovf}
  function automatic logic [5:0] model4(input logic [3:0] ma, input logic [3:0] mb,
                                        input logic mcin, input logic msub);
    logic [3:0] bb;
    logic [4:0] r;
    logic       c0, v;
    bb = msub ? ~mb : mb;
    c0 = msub ? 1'b1 : mcin;
    r  = {1'b0, ma} + {1'b0, bb} + {4'b0, c0};
    v  = (ma[3] == bb[3]) && (r[3] != ma[3]);
    return {r[3:0], r[4], v};
  endfunction

  // Scoreboard monitors: pop and compare whenever a result is presented
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt8++;
      if (exp8_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut8_unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        e8 = exp8_q.pop_front();
        check("dut8_sum", sum, e8[9:2]);
        check("dut8_co", co, e8[1]);
        check("dut8_ovf", ovf, e8[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s4_done) begin
      if (exp4_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut4_unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        e4 = exp4_q.pop_front();
        check("dut4_sum", s4_sum, e4[5:2]);
        check("dut4_co", s4_co, e4[1]);
        check("dut4_ovf", s4_ovf, e4[0]);
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("dut8_idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (s4_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("dut4_idle_timeout", s4_busy, 1'b0);
  endtask

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                        input logic isub, input logic push, input logic [9:0] iexp);
    wait_idle8();
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    if (push) exp8_q.push_back(iexp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] ia, input logic [3:0] ib, input logic icin, input logic isub);
    wait_idle4();
    s4_a = ia; s4_b = ib; s4_cin = icin; s4_sub = isub; s4_start = 1'b1;
    exp4_q.push_back(model4(ia, ib, icin, isub));
    @(posedge clk); #1;
    s4_start = 1'b0;
  endtask

  logic [7:0] tp_a[3] = '{8'h12, 8'h80, 8'h40};
  logic [7:0] tp_b[3] = '{8'h34, 8'h80, 8'h3F};
  logic       tp_c[3] = '{1'b0, 1'b0, 1'b1};
  logic [9:0] tp_e[3] = '{{8'h46, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b1}, {8'h80, 1'b0, 1'b1}};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [7:0] op_a, op_b;
    logic       c;
    int         done_base;

    rst = 1'b1;
    start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    s4_start = 1'b0; s4_sub = 1'b0; s4_cin = 1'b0; s4_a = '0; s4_b = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_co", co, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_fa", {fa_a, fa_b, fa_ci}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;

    // First operation with per-cycle adder-drive checks
    op_a = 8'h5A; op_b = 8'h3C; c = 1'b0;
    a = op_a; b = op_b; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp8_q.push_back({8'h96, 1'b0, 1'b1});
    @(posedge clk); #1;
    start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("run_fa_A", fa_a, op_a[i]);
      check("run_fa_B", fa_b, op_b[i]);
      check("run_fa_Ci", fa_ci, c);
      check("run_busy", busy, 1'b1);
      check("run_done", done, 1'b0);
      c = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("done_at_8_edges", done, 1'b1);
    check("done_busy", busy, 1'b1);
    check("done_fa", {fa_a, fa_b, fa_ci}, 3'b000);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_done_busy", busy, 1'b0);
    check("after_done_done", done, 1'b0);
    @(posedge clk); #1;

    // Directed add/subtract corners
    issue8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, {8'h00, 1'b1, 1'b0});
    @(negedge clk);
    check("sum_hold_during_run", sum, 8'h96);
    @(posedge clk); #1;
    issue8(8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, {8'h80, 1'b0, 1'b1});
    issue8(8'h10, 8'h01, 1'b0, 1'b1, 1'b1, {8'h0F, 1'b1, 1'b0});
    issue8(8'h00, 8'h01, 1'b1, 1'b1, 1'b1, {8'hFF, 1'b0, 1'b0});

    // start held high; operands change every cycle, only accept-edge values count
    wait_idle8();
    done_base = done_cnt8;
    for (int k = 0; k < 30; k++) begin
      start = 1'b1;
      sub = 1'b0;
      if (k % 10 == 0) begin
        a = tp_a[k / 10]; b = tp_b[k / 10]; cin = tp_c[k / 10];
        exp8_q.push_back(tp_e[k / 10]);
      end else begin
        a = 8'(k * 29 + 7); b = 8'(k * 13 + 101); cin = k[0];
      end
      @(negedge clk);
      check("held_start_done_timing", done, (k % 10 == 9));
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("held_start_done_count", done_cnt8 - done_base, 3);

    // Reset in the 4th RUN cycle discards the operation
    wait_idle8();
    issue8(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 10'h0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_done", done, 1'b0);
    check("midrun_rst_sum", sum, 8'h00);
    check("midrun_rst_co", co, 1'b0);
    check("midrun_rst_ovf", ovf, 1'b0);
    check("midrun_rst_fa", {fa_a, fa_b, fa_ci}, 3'b000);
    @(posedge clk); #1;
    issue8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, {8'h02, 1'b0, 1'b0});
    wait_idle8();
    @(posedge clk); #1;
    check("dut8_scoreboard_drained", exp8_q.size(), 0);

    // Exhaustive WIDTH=4 sweep
    for (int s = 0; s < 2; s++)
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++)
          for (int ic = 0; ic < 2; ic++)
            issue4(4'(ia), 4'(ib), ic[0], s[0]);
    wait_idle4();
    @(posedge clk); #1;
    check("dut4_scoreboard_drained", exp4_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
